// File: rtl/alu_issue_queue.sv
// Sequential front end for a combinational ALU: buffers tagged commands in a FIFO,
// issues one at a time through registered operands, and returns the tagged result.
module alu_issue_queue #(
  parameter int WIDTH = 128,
  parameter int OPW   = 4,
  parameter int SHW   = 5,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_opcode,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [SHW-1:0]             in_shift,
  input  logic [TAGW-1:0]            in_tag,
  output logic [OPW-1:0]             alu_opcode,
  output logic [WIDTH-1:0]           alu_input1,
  output logic [WIDTH-1:0]           alu_input2,
  output logic [SHW-1:0]             alu_shift,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_carry,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_carry,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH)+1:0]   pending
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int PNDW = PTRW + 2;
  localparam int ENTW = OPW + 2 * WIDTH + SHW + TAGW;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  logic [ENTW-1:0]  mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full, empty, push, pop;

  logic [OPW-1:0]   head_opcode;
  logic [WIDTH-1:0] head_a, head_b;
  logic [SHW-1:0]   head_shift;
  logic [TAGW-1:0]  head_tag;

  state_t           state_q, state_d;
  logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d, alu_input2_q, alu_input2_d;
  logic [SHW-1:0]   alu_shift_q, alu_shift_d;
  logic [TAGW-1:0]  issue_tag_q, issue_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic [TAGW-1:0]  out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic [PNDW-1:0]  pending_q, pending_d;

  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid && !full;
  assign in_ready = !full;

  assign {head_opcode, head_a, head_b, head_shift, head_tag} = mem_q[rd_ptr_q];

  // Storage is not reset: the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_opcode, in_a, in_b, in_shift, in_tag};
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_input1_d = alu_input1_q;
    alu_input2_d = alu_input2_q;
    alu_shift_d  = alu_shift_q;
    issue_tag_d  = issue_tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_valid_d = 1'b1;
        out_tag_d   = issue_tag_q;
        if (alu_opcode_q > OPW'(8)) begin
          out_result_d = '0;
          out_carry_d  = 1'b0;
          out_err_d    = 1'b1;
        end else begin
          out_result_d = alu_result;
          out_carry_d  = alu_carry;
          out_err_d    = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands only change on a load, so the ALU sees them stable through EXEC.
    if (pop) begin
      alu_opcode_d = head_opcode;
      alu_input1_d = head_a;
      alu_input2_d = head_b;
      alu_shift_d  = head_shift;
      issue_tag_d  = head_tag;
    end

    wr_ptr_d  = wr_ptr_q + PTRW'(push);
    rd_ptr_d  = rd_ptr_q + PTRW'(pop);
    count_d   = count_q + CNTW'(push) - CNTW'(pop);
    pending_d = PNDW'(count_d) + PNDW'(state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
      issue_tag_q  <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_input1_q <= alu_input1_d;
      alu_input2_q <= alu_input2_d;
      alu_shift_q  <= alu_shift_d;
      issue_tag_q  <= issue_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      pending_q    <= pending_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_input1 = alu_input1_q;
  assign alu_input2 = alu_input2_q;
  assign alu_shift  = alu_shift_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: a small ALU stand-in, a vector table for
// per-opcode results, and hand-written sequences for stall, ordering and reset.
module tb_alu_issue_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [127:0] in_a, in_b;
  logic [4:0]   in_shift;
  logic [3:0]   in_tag;
  logic [3:0]   alu_opcode;
  logic [127:0] alu_input1, alu_input2;
  logic [4:0]   alu_shift;
  logic [127:0] alu_result;
  logic         alu_carry;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic         out_carry;
  logic [3:0]   out_tag;
  logic         out_err;
  logic [3:0]   pending;

  int checks   = 0;
  int failures = 0;
  int next_push;
  int next_expect;

  typedef struct {
    logic [3:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [4:0]   sh;
    logic [3:0]   tag;
    logic [127:0] exp_res;
    logic         exp_carry;
    logic         exp_err;
  } vec_t;

  vec_t vecs [11];

  alu_issue_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shift(in_shift), .in_tag(in_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_tag(out_tag), .out_err(out_err), .pending(pending)
  );

  always #5 clk = ~clk;

  // ALU stand-in; illegal opcodes drive all-ones and carry so suppression is visible.
  always_comb begin
    alu_result = alu_input1;
    alu_carry  = 1'b0;
    case (alu_opcode)
      4'd0: {alu_carry, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1: begin
        alu_result = alu_input1 - alu_input2;
        alu_carry  = alu_input1 < alu_input2;
      end
      4'd2: alu_result = alu_input1 & alu_input2;
      4'd3: alu_result = alu_input1 | alu_input2;
      4'd5: alu_result = alu_input1 ^ alu_input2;
      4'd6: alu_result = alu_input1 << alu_shift;
      4'd8: alu_result = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
      default: begin
        if (alu_opcode > 4'd8) begin
          alu_result = '1;
          alu_carry  = 1'b1;
        end
      end
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                                input logic [4:0] sh, input logic [3:0] tag);
    int guard = 0;
    in_opcode = op; in_a = a; in_b = b; in_shift = sh; in_tag = tag;
    in_valid  = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_output("push_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check_output("wait_valid", 128'(out_valid), 128'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Streams tagged XOR commands; result of tag i is {i, i} since b is zero.
  task automatic run_stream(input int total, input int max_cycles);
    int   cyc      = 0;
    int   last_cyc = -1;
    logic fire;
    out_ready = 1'b1;
    while (next_expect < total && cyc < max_cycles) begin
      if (next_push < total) begin
        in_opcode = 4'd5;
        in_a      = {64'(next_push), 64'(next_push)};
        in_b      = '0;
        in_shift  = '0;
        in_tag    = 4'(next_push);
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      fire = in_valid && in_ready;
      if (out_valid) begin
        check_output("stream_tag", 128'(out_tag), 128'(next_expect));
        check_output("stream_result", out_result, {64'(next_expect), 64'(next_expect)});
        if (last_cyc >= 0) check_output("stream_spacing", 128'(cyc - last_cyc), 128'd2);
        last_cyc = cyc;
        next_expect++;
      end
      tick();
      if (fire) next_push++;
      cyc++;
    end
    in_valid = 1'b0;
    check_output("stream_done", 128'(next_expect), 128'(total));
    tick();
    out_ready = 1'b0;
    check_output("stream_idle_valid", 128'(out_valid), 128'd0);
    check_output("stream_idle_pending", 128'(pending), 128'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd5, 128'hF0, 128'hFF, 5'd0, 4'd3, 128'h0F, 1'b0, 1'b0};
    vecs[1]  = '{4'd0, '1, 128'h1, 5'd0, 4'd1, 128'h0, 1'b1, 1'b0};
    vecs[2]  = '{4'd0, 128'h5, 128'h7, 5'd0, 4'd2, 128'hC, 1'b0, 1'b0};
    vecs[3]  = '{4'd1, 128'hA, 128'h3, 5'd0, 4'd4, 128'h7, 1'b0, 1'b0};
    vecs[4]  = '{4'd1, 128'h3, 128'hA, 5'd0, 4'd5,
                 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF9, 1'b1, 1'b0};
    vecs[5]  = '{4'd2, 128'hF0F0, 128'h0FF0, 5'd0, 4'd6, 128'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{4'd3, 128'h0F, 128'hF0, 5'd0, 4'd7, 128'hFF, 1'b0, 1'b0};
    vecs[7]  = '{4'd6, 128'h1, 128'h0, 5'd31, 4'd8, 128'h8000_0000, 1'b0, 1'b0};
    vecs[8]  = '{4'd8, 128'h5, 128'h9, 5'd0, 4'd9, 128'h9, 1'b0, 1'b0};
    vecs[9]  = '{4'd12, 128'hF, 128'h1, 5'd0, 4'd11, 128'h0, 1'b0, 1'b1};
    vecs[10] = '{4'd5, 128'h3, 128'h1, 5'd0, 4'd10, 128'h2, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_a = '0; in_b = '0; in_shift = '0; in_tag = '0;
    tick();
    check_output("rst_out_valid", 128'(out_valid), 128'd0);
    check_output("rst_pending", 128'(pending), 128'd0);
    check_output("rst_alu_opcode", 128'(alu_opcode), 128'd0);
    check_output("rst_alu_input1", alu_input1, 128'd0);
    check_output("rst_out_result", out_result, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check_output("rst_in_ready", 128'(in_ready), 128'd1);

    // Single command latency: pushed at edge T, out_valid after T+2.
    apply_stimulus(4'd5, 128'hF0, 128'hFF, 5'd0, 4'd3);
    check_output("lat_t0_valid", 128'(out_valid), 128'd0);
    check_output("lat_t0_pending", 128'(pending), 128'd1);
    tick();
    check_output("lat_t1_valid", 128'(out_valid), 128'd0);
    check_output("lat_t1_pending", 128'(pending), 128'd1);
    check_output("lat_t1_alu_op", 128'(alu_opcode), 128'd5);
    check_output("lat_t1_alu_in1", alu_input1, 128'hF0);
    tick();
    check_output("lat_t2_valid", 128'(out_valid), 128'd1);
    check_output("lat_t2_result", out_result, 128'h0F);
    check_output("lat_t2_tag", 128'(out_tag), 128'd3);
    check_output("lat_t2_err", 128'(out_err), 128'd0);
    handshake();
    check_output("lat_done_valid", 128'(out_valid), 128'd0);
    check_output("lat_done_pending", 128'(pending), 128'd0);

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].tag);
      wait_valid(10);
      check_output($sformatf("vec%0d_result", i), out_result, vecs[i].exp_res);
      check_output($sformatf("vec%0d_carry", i), 128'(out_carry), 128'(vecs[i].exp_carry));
      check_output($sformatf("vec%0d_tag", i), 128'(out_tag), 128'(vecs[i].tag));
      check_output($sformatf("vec%0d_err", i), 128'(out_err), 128'(vecs[i].exp_err));
      handshake();
      check_output($sformatf("vec%0d_pending", i), 128'(pending), 128'd0);
    end

    // Backpressure: the MAX result must hold steady while downstream stalls.
    apply_stimulus(4'd8, 128'h1, 128'h0, 5'd0, 4'd7);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      check_output("hold_valid", 128'(out_valid), 128'd1);
      check_output("hold_result", out_result, 128'h1);
      check_output("hold_carry", 128'(out_carry), 128'd0);
      check_output("hold_tag", 128'(out_tag), 128'd7);
      tick();
    end
    handshake();

    // Fill and stall: four queued plus one in flight blocks tag 5.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'd5, {64'(i), 64'(i)}, 128'h0, 5'd0, 4'(i));
    end
    check_output("fill_in_ready", 128'(in_ready), 128'd0);
    check_output("fill_pending", 128'(pending), 128'd5);
    in_opcode = 4'd5; in_a = {64'd5, 64'd5}; in_b = '0; in_tag = 4'd5; in_valid = 1'b1;
    repeat (3) tick();
    check_output("stall_in_ready", 128'(in_ready), 128'd0);
    check_output("stall_pending", 128'(pending), 128'd5);
    check_output("stall_out_tag", 128'(out_tag), 128'd0);
    next_push = 5; next_expect = 0;
    run_stream(6, 100);

    // Simultaneous push and pop at two FIFO entries, then ten commands with wrap.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(4'd5, {64'(i), 64'(i)}, 128'h0, 5'd0, 4'(i));
    end
    repeat (2) tick();
    check_output("pp_pending_before", 128'(pending), 128'd3);
    check_output("pp_valid_before", 128'(out_valid), 128'd1);
    in_opcode = 4'd5; in_a = {64'd3, 64'd3}; in_b = '0; in_tag = 4'd3; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("pp_pending_after", 128'(pending), 128'd3);
    next_push = 4; next_expect = 1;
    run_stream(10, 200);

    // Reset with three queued and one command in EXEC.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'd5, 128'(i), 128'h0, 5'd0, 4'(i));
    end
    repeat (2) tick();
    in_opcode = 4'd5; in_a = 128'h4; in_b = '0; in_tag = 4'd4; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_output("prerst_pending", 128'(pending), 128'd4);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_valid", 128'(out_valid), 128'd0);
    check_output("midrst_pending", 128'(pending), 128'd0);
    check_output("midrst_alu_op", 128'(alu_opcode), 128'd0);
    check_output("midrst_alu_in1", alu_input1, 128'd0);
    check_output("midrst_tag", 128'(out_tag), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check_output("postrst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_output("postrst_no_valid", 128'(out_valid), 128'd0);
      tick();
    end
    apply_stimulus(4'd0, 128'h2, 128'h3, 5'd0, 4'd9);
    check_output("rlat_t0_valid", 128'(out_valid), 128'd0);
    tick();
    check_output("rlat_t1_valid", 128'(out_valid), 128'd0);
    tick();
    check_output("rlat_t2_valid", 128'(out_valid), 128'd1);
    check_output("rlat_t2_result", out_result, 128'h5);
    check_output("rlat_t2_tag", 128'(out_tag), 128'd9);
    tick();
    out_ready = 1'b0;
    check_output("rlat_pending", 128'(pending), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Sequential front end for the combinational 128-bit ALU.
- Accepts ALU commands (opcode, two operands, shift amount, tag) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one command at a time to the ALU through registered operand outputs, captures the ALU result and carry one cycle later, and presents them downstream with the tag over a second valid/ready handshake.

Parameters:
- WIDTH, 128, operand/result width
- OPW, 4, opcode width
- SHW, 5, shift-amount width
- TAGW, 4, command tag width
- DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid&&in_ready at clk edge
- in_opcode  input  OPW  command opcode
- in_a  input  WIDTH  operand 1
- in_b  input  WIDTH  operand 2
- in_shift  input  SHW  shift amount
- in_tag  input  TAGW  command tag
- alu_opcode  output  OPW  registered, drives ALU opcode
- alu_input1  output  WIDTH  registered, drives ALU input1
- alu_input2  output  WIDTH  registered, drives ALU input2
- alu_shift  output  SHW  registered, drives ALU shiftValue
- alu_result  input  WIDTH  ALU result (combinational from alu_* outputs)
- alu_carry  input  1  ALU carryFlag
- out_valid  output  1  result valid
- out_ready  input  1  downstream ready
- out_result  output  WIDTH  captured result
- out_carry  output  1  captured carry
- out_tag  output  TAGW  tag of the command
- out_err  output  1  opcode was illegal (>8)
- pending  output  $clog2(DEPTH)+2  commands in FIFO plus in issue/output

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; state IDLE.
  - All registered outputs 0: alu_*, out_*, pending.
  - in_ready=1 once rst deasserts.
  - A reset mid-operation discards every queued and in-flight command; no out_valid pulse follows.
- FIFO:
  - in_ready = !full (combinational from count only; no dependence on in_valid or out_ready).
  - Push on in_valid&&in_ready. Pop only by the issue FSM.
  - Simultaneous push and pop is legal at any occupancy except that a push while full cannot occur.
  - Pointers wrap modulo DEPTH. No bypass: a pushed command is visible to the FSM the cycle after it is written.
- Issue FSM, states IDLE, EXEC, OUT:
  - IDLE: if FIFO non-empty, load head into alu_* and the tag/opcode shadow registers, pop, go to EXEC.
  - EXEC (exactly 1 cycle): capture alu_result/alu_carry into out_result/out_carry, set out_tag, set out_valid<=1, go to OUT.
    - If the issued opcode is >8: out_result<=0, out_carry<=0, out_err<=1. Otherwise out_err<=0.
  - OUT: hold all out_* stable while out_valid&&!out_ready. On out_valid&&out_ready: out_valid<=0.
    - Same edge: if FIFO non-empty, load and pop the next command and go to EXEC; else go to IDLE.
- alu_* hold their last issued values outside load edges. The ALU inputs are therefore stable for the whole EXEC cycle and beyond.
- Latency:
  - Command pushed at edge T into an idle, empty block: popped at T+1; out_valid high after edge T+2.
  - Back-to-back throughput with out_ready held high: one result per 2 cycles.
- Ordering: results emerge strictly in push order; tags are passed through unmodified.
- pending = FIFO count + (state!=IDLE). Maximum value DEPTH+1.
  - Increments on push and decrements on output handshake; both on the same edge leaves it unchanged.
- out_valid never drops without a handshake, except on reset.

Test Plan:
- Single command: push opcode=5 (XOR), a=0xF0, b=0xFF, tag=3; ALU model returns a^b.
  - Expect out_valid after 3 edges, out_result=0x0F, out_tag=3, out_err=0, pending 1 then 0.
- Fill and stall: out_ready=0, push 6 commands (tags 0..5).
  - Expect in_ready=0 after tag 4 is accepted (4 in FIFO + 1 in flight), pending=5, tag 5 held.
  - Release out_ready: tags emerge 0..5 in order, one per 2 cycles.
- Backpressure hold: out_ready low for 10 cycles with a MAX result 128'h1 pending.
  - Expect out_result, out_carry and out_tag constant and out_valid high throughout.
- Illegal opcode: push opcode=12 while the ALU model drives alu_result=all-ones and alu_carry=1.
  - Expect out_result=0, out_carry=0, out_err=1; the next legal command gives out_err=0.
- Simultaneous push/pop: FIFO at 2 entries, push while the FSM pops on the same edge.
  - Expect count unchanged and no entry lost or duplicated; verify with pointer wrap over 10 commands.
- Reset mid-operation: assert rst asynchronously with 3 queued and 1 in EXEC.
  - Expect all outputs 0 immediately and no out_valid after release; a new command completes normally with 3-edge latency.
